conv_line_window: RTL and testbench
===================================

// Module: conv_line_window
// PURPOSE
//  Upstream feeder of the convolution engine. Accepts a raster pixel stream,
//  stores the two previous image lines and emits a 3x3 pixel window per pixel.
//  Sits in parallel with the sync/control delay FIFO: pixels go here, sync bits go to the FIFO.
//  Window output drives the conv engine MAC array directly.
// PARAMETERS
//  DATA_W      24    pixel width (RGB888)
//  IMG_WIDTH   1920  pixels per line
//  IMG_HEIGHT  1080  lines per frame
//  ADDR_W      11    column counter / line RAM address width; 2**ADDR_W >= IMG_WIDTH
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  pix_in     in   DATA_W     incoming pixel
//  pix_valid  in   1          pix_in is valid this cycle; no backpressure
//  sof        in   1          start of frame, qualified by pix_valid; marks pixel (0,0)
//  win_out    out  9*DATA_W   3x3 window, element k=r*3+c at [k*DATA_W +: DATA_W]
//  win_valid  out  1          win_out holds a complete window (1-cycle pulse)
//  col_cnt    out  ADDR_W     column of next expected pixel
//  row_cnt    out  11         row of next expected pixel
// BEHAVIOUR
//  - Reset: win_out=0, win_valid=0, col_cnt=0, row_cnt=0, window regs=0.
//    Line RAM contents are not reset; masked by win_valid rules.
//  - Two line RAMs (depth IMG_WIDTH): lb1 = row r-1, lb2 = row r-2, at column c.
//    On accepted pixel at (r,c): read lb1[c], lb2[c]; then write lb2[c]<=lb1[c], lb1[c]<=pix_in.
//    Read-before-write in the same cycle.
//  - Window regs: 3 rows x 3 cols. On accept, each row shifts left (col0 <- col1 <- col2).
//    New col2 = {lb2[c], lb1[c], pix_in} for rows 0,1,2.
//    r=0 is the top (oldest) row, c=0 the leftmost (oldest) column.
//  - Latency: 1 cycle. The accept at (r,c) updates win_out on the next edge.
//    win_valid=1 on that edge iff r>=2 && c>=2; otherwise 0.
//  - pix_valid=0 cycles: no shift, no RAM write, counters hold, win_out holds, win_valid=0.
//  - Counters advance only on accept.
//    col wraps IMG_WIDTH-1 -> 0 and row increments; row wraps IMG_HEIGHT-1 -> 0.
//  - Window regs are not cleared at line start; win_valid gating (c>=2) hides stale columns.
//  - sof && pix_valid: pixel is treated as (0,0) regardless of counters.
//    Next expected is (0,1); partial line/frame is discarded.
//  - sof without pix_valid is ignored.
//  - rst mid-line has priority over everything.
//    Stream restarts at (0,0); first win_valid only after two full new lines.
//  - Valid windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//  - Widths: no arithmetic on pixel data; counters unsigned, compared with ==.
// CONFIGURATION
//  LB_ERR_CHECK_EN defined: adds output port line_err (1 bit, reset 0).
//    Sticky set when sof&&pix_valid arrives with (col_cnt,row_cnt)!=(0,0).
//    Also set when pix_valid arrives at (0,0) without sof after the first frame.
//    Cleared only by rst.
//  LB_ERR_CHECK_EN undefined: no line_err port, no check logic; behaviour otherwise identical.
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*16+col)
//  1. Continuous frame with sof on first pixel -> first win_valid the cycle after pixel 0x22.
//     win_out k0=0x00, k2=0x02, k4=0x11, k8=0x22; exactly 4 win_valid pulses.
//  2. Same frame, pix_valid low on every other cycle -> identical window sequence.
//     win_out stable and win_valid=0 on idle cycles.
//  3. Two back-to-back frames, second with values +0x80 -> second frame windows contain
//     only 0x80+ values; counters wrap 3->0 correctly.
//  4. rst asserted after pixel 0x12 of frame 1, then new frame -> outputs/counters 0 next edge;
//     no win_valid until pixel 0x22 of new frame.
//  5. sof pulsed at pixel (1,2) -> counters jump to (0,1); next win_valid only at new (2,2).
//  6. With LB_ERR_CHECK_EN: scenario 5 sets line_err=1 and it stays 1 until rst;
//     a clean frame leaves it 0.

Source files
------------

// File: rtl/conv_line_window_if.sv
// Pixel-stream / window bundle between the raster source and conv_line_window.
// master = pixel source side, slave = line-window side.
interface conv_line_window_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11
);
  logic [DATA_W-1:0]   pix_in;
  logic                pix_valid;
  logic                sof;
  logic [9*DATA_W-1:0] win_out;
  logic                win_valid;
  logic [ADDR_W-1:0]   col_cnt;
  logic [ROW_W-1:0]    row_cnt;

  modport master (
    output pix_in, pix_valid, sof,
    input  win_out, win_valid, col_cnt, row_cnt
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output win_out, win_valid, col_cnt, row_cnt
  );
endinterface

// File: rtl/conv_line_window.sv
// Two-line buffer plus 3x3 window register for the convolution engine (1-cycle latency).
// Optional LB_ERR_CHECK_EN adds a sticky line_err output for stream framing errors.
module conv_line_window #(
  parameter int DATA_W     = 24,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int ADDR_W     = 11
) (
  input  logic               clk,
  input  logic               rst,
  conv_line_window_if.slave  bus
`ifdef LB_ERR_CHECK_EN
  ,
  output logic               line_err
`endif
);

  localparam int ROW_W = 11;
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb2_mem [IMG_WIDTH];

  logic [ADDR_W-1:0]   col_reg, col_next, col_eff;
  logic [ROW_W-1:0]    row_reg, row_next, row_eff;
  logic                win_valid_reg, win_valid_next;
  logic                accept;
  logic [DATA_W-1:0]   lb1_rd, lb2_rd;
  logic [DATA_W-1:0]   col_src [3];
  logic [9*DATA_W-1:0] win_flat;

  // sof forces the current pixel to (0,0) no matter where the counters are
  always_comb begin
    accept         = bus.pix_valid;
    col_eff        = bus.sof ? '0 : col_reg;
    row_eff        = bus.sof ? '0 : row_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    win_valid_next = 1'b0;
    if (accept) begin
      win_valid_next = (row_eff >= ROW_W'(2)) && (col_eff >= ADDR_W'(2));
      if (col_eff == COL_LAST) begin
        col_next = '0;
        row_next = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_next = col_eff + ADDR_W'(1);
        row_next = row_eff;
      end
    end
  end

  // Old line contents are read combinationally so the window sees them in the same cycle
  assign lb1_rd     = lb1_mem[col_eff];
  assign lb2_rd     = lb2_mem[col_eff];
  assign col_src[0] = lb2_rd;
  assign col_src[1] = lb1_rd;
  assign col_src[2] = bus.pix_in;

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb1_mem[col_eff] <= bus.pix_in;
      lb2_mem[col_eff] <= lb1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg       <= '0;
      row_reg       <= '0;
      win_valid_reg <= 1'b0;
    end else begin
      col_reg       <= col_next;
      row_reg       <= row_next;
      win_valid_reg <= win_valid_next;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_W-1:0] tap [3];

      always_ff @(posedge clk) begin
        if (rst) begin
          tap <= '{default: '0};
        end else if (accept) begin
          tap[0] <= tap[1];
          tap[1] <= tap[2];
          tap[2] <= col_src[gi];
        end
      end

      for (gj = 0; gj < 3; gj++) begin : g_col
        assign win_flat[(gi*3+gj)*DATA_W +: DATA_W] = tap[gj];
      end
    end
  endgenerate

  assign bus.win_out   = win_flat;
  assign bus.win_valid = win_valid_reg;
  assign bus.col_cnt   = col_reg;
  assign bus.row_cnt   = row_reg;

`ifdef LB_ERR_CHECK_EN
  logic line_err_reg;
  logic frame_done_reg;

  // A pixel at (0,0) without sof is only suspicious once a whole frame has gone by
  always_ff @(posedge clk) begin
    if (rst) begin
      line_err_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else if (accept) begin
      if (bus.sof && (col_reg != '0 || row_reg != '0))
        line_err_reg <= 1'b1;
      if (!bus.sof && col_reg == '0 && row_reg == '0 && frame_done_reg)
        line_err_reg <= 1'b1;
      if (col_eff == COL_LAST && row_eff == ROW_LAST)
        frame_done_reg <= 1'b1;
    end
  end

  assign line_err = line_err_reg;
`endif

endmodule

// File: tb/tb_conv_line_window.sv
// Self-checking bench for conv_line_window on a 4x4 image against a frame-array reference model.
module tb_conv_line_window;
  localparam int DW = 24;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_line_window_if #(.DATA_W(DW), .ADDR_W(AW), .ROW_W(11)) bus ();
`ifdef LB_ERR_CHECK_EN
  logic line_err;
`endif

  conv_line_window #(
    .DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LB_ERR_CHECK_EN
    ,
    .line_err(line_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame stored by (row, col); window read straight from it
  int               m_r, m_c;
  logic [DW-1:0]    m_img [H][W];
  bit               m_have;
  logic [9*DW-1:0]  m_last;
  bit               exp_valid;
  logic [9*DW-1:0]  exp_win;
  logic [AW-1:0]    exp_col;
  logic [10:0]      exp_row;

  task automatic model_reset();
    m_r = 0; m_c = 0;
    m_have = 1; m_last = '0;
    exp_valid = 0; exp_win = '0;
    exp_col = '0; exp_row = '0;
  endtask

  task automatic step(input bit v, input bit s, input logic [DW-1:0] p);
    bus.pix_valid = v;
    bus.sof       = s;
    bus.pix_in    = p;
    exp_valid     = 0;
    if (v) begin
      if (s) begin m_r = 0; m_c = 0; end
      m_img[m_r][m_c] = p;
      exp_valid = (m_r >= 2) && (m_c >= 2);
      if (exp_valid) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            exp_win[(rr*3+cc)*DW +: DW] = m_img[m_r-2+rr][m_c-2+cc];
        m_last = exp_win;
        m_have = 1;
      end else begin
        m_have = 0;
      end
      m_c++;
      if (m_c == W) begin m_c = 0; m_r = (m_r + 1) % H; end
    end
    exp_col = AW'(m_c);
    exp_row = 11'(m_r);
    @(posedge clk); #1;
    bus.pix_valid = 0;
    bus.sof       = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    bus.pix_valid = 1;
    bus.sof = 0;
    bus.pix_in = DW'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst = 0;
    bus.pix_valid = 0;
    model_reset();
  endtask

  function automatic logic [DW-1:0] pv(input int r, input int c, input int base);
    return DW'(base + r*16 + c);
  endfunction

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if (bus.win_out !== '0) begin n_fail++; $display("FAIL reset_win: got %h expected 0", bus.win_out); end
    n_checks++;
    if (bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.win_valid); end
    n_checks++;
    if (bus.col_cnt !== '0 || bus.row_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got (%0d,%0d) expected (0,0)", bus.row_cnt, bus.col_cnt);
    end
`ifdef LB_ERR_CHECK_EN
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL reset_line_err: got %b expected 0", line_err); end
`endif
  endtask

  task automatic test_continuous();
    int pulses = 0;
    int first_i = -1;
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, pv(i / W, i % W, 0));
      n_checks++;
      if (bus.win_valid !== exp_valid) begin
        n_fail++; $display("FAIL cont_valid i=%0d: got %b expected %b", i, bus.win_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (bus.win_out !== exp_win) begin n_fail++; $display("FAIL cont_win i=%0d: got %h expected %h", i, bus.win_out, exp_win); end
      end
      n_checks++;
      if (bus.col_cnt !== exp_col || bus.row_cnt !== exp_row) begin
        n_fail++; $display("FAIL cont_cnt i=%0d: got (%0d,%0d) expected (%0d,%0d)", i, bus.row_cnt, bus.col_cnt, exp_row, exp_col);
      end
      if (bus.win_valid === 1'b1) begin
        pulses++;
        if (first_i < 0) begin
          first_i = i;
          n_checks++;
          if (bus.win_out[0*DW +: DW] !== 24'h00 || bus.win_out[2*DW +: DW] !== 24'h02 ||
              bus.win_out[4*DW +: DW] !== 24'h11 || bus.win_out[8*DW +: DW] !== 24'h22) begin
            n_fail++; $display("FAIL cont_first_win: got %h expected k0=00 k2=02 k4=11 k8=22", bus.win_out);
          end
        end
      end
    end
    n_checks++;
    if (first_i != 10) begin n_fail++; $display("FAIL cont_first_pos: got %0d expected 10", first_i); end
    n_checks++;
    if (pulses != 4) begin n_fail++; $display("FAIL cont_pulses: got %0d expected 4", pulses); end
`ifdef LB_ERR_CHECK_EN
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL clean_line_err: got %b expected 0", line_err); end
`endif
  endtask

  task automatic test_gaps();
    int pulses = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, pv(i / W, i % W, 0));
      n_checks++;
      if (bus.win_valid !== exp_valid) begin
        n_fail++; $display("FAIL gap_valid i=%0d: got %b expected %b", i, bus.win_valid, exp_valid);
      end
      if (exp_valid) begin
        pulses++;
        n_checks++;
        if (bus.win_out !== exp_win) begin n_fail++; $display("FAIL gap_win i=%0d: got %h expected %h", i, bus.win_out, exp_win); end
      end
      step(0, $urandom_range(0, 1), DW'($urandom));
      n_checks++;
      if (bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL gap_idle_valid i=%0d: got %b expected 0", i, bus.win_valid); end
      if (m_have) begin
        n_checks++;
        if (bus.win_out !== m_last) begin n_fail++; $display("FAIL gap_idle_hold i=%0d: got %h expected %h", i, bus.win_out, m_last); end
      end
      n_checks++;
      if (bus.col_cnt !== exp_col || bus.row_cnt !== exp_row) begin
        n_fail++; $display("FAIL gap_idle_cnt i=%0d: got (%0d,%0d) expected (%0d,%0d)", i, bus.row_cnt, bus.col_cnt, exp_row, exp_col);
      end
    end
    n_checks++;
    if (pulses != 4) begin n_fail++; $display("FAIL gap_pulses: got %0d expected 4", pulses); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W*H; i++) begin
        step(1, i == 0, pv(i / W, i % W, f * 8'h80));
        n_checks++;
        if (bus.win_valid !== exp_valid) begin
          n_fail++; $display("FAIL b2b_valid f=%0d i=%0d: got %b expected %b", f, i, bus.win_valid, exp_valid);
        end
        if (exp_valid) begin
          n_checks++;
          if (bus.win_out !== exp_win) begin n_fail++; $display("FAIL b2b_win f=%0d i=%0d: got %h expected %h", f, i, bus.win_out, exp_win); end
          if (f == 1) begin
            for (int k = 0; k < 9; k++) begin
              n_checks++;
              if (bus.win_out[k*DW +: DW] < 24'h80) begin
                n_fail++; $display("FAIL b2b_new_only i=%0d k=%0d: got %h expected >=80", i, k, bus.win_out[k*DW +: DW]);
              end
            end
          end
        end
        n_checks++;
        if (bus.col_cnt !== exp_col || bus.row_cnt !== exp_row) begin
          n_fail++; $display("FAIL b2b_cnt f=%0d i=%0d: got (%0d,%0d) expected (%0d,%0d)", f, i, bus.row_cnt, bus.col_cnt, exp_row, exp_col);
        end
      end
      n_checks++;
      if (bus.col_cnt !== '0 || bus.row_cnt !== '0) begin
        n_fail++; $display("FAIL b2b_wrap f=%0d: got (%0d,%0d) expected (0,0)", f, bus.row_cnt, bus.col_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first_i = -1;
    for (int i = 0; i <= 6; i++) step(1, i == 0, pv(i / W, i % W, 0));
    rst = 1;
    bus.pix_valid = 1; bus.sof = 0; bus.pix_in = 24'h13;
    @(posedge clk); #1;
    rst = 0; bus.pix_valid = 0;
    model_reset();
    n_checks++;
    if (bus.win_out !== '0 || bus.win_valid !== 1'b0 || bus.col_cnt !== '0 || bus.row_cnt !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got win=%h v=%b cnt=(%0d,%0d) expected all 0", bus.win_out, bus.win_valid, bus.row_cnt, bus.col_cnt);
    end
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, pv(i / W, i % W, 8'h40));
      n_checks++;
      if (bus.win_valid !== exp_valid) begin
        n_fail++; $display("FAIL rstmid_valid i=%0d: got %b expected %b", i, bus.win_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (bus.win_out !== exp_win) begin n_fail++; $display("FAIL rstmid_win i=%0d: got %h expected %h", i, bus.win_out, exp_win); end
      end
      if (bus.win_valid === 1'b1 && first_i < 0) first_i = i;
    end
    n_checks++;
    if (first_i != 10) begin n_fail++; $display("FAIL rstmid_first: got %0d expected 10", first_i); end
  endtask

  task automatic test_sof_mid();
    int first_n = -1;
    for (int i = 0; i < 6; i++) step(1, i == 0, pv(i / W, i % W, 0));
    step(1, 1, 24'h12);
    n_checks++;
    if (bus.col_cnt !== 2'd1 || bus.row_cnt !== 11'd0) begin
      n_fail++; $display("FAIL sofmid_jump: got (%0d,%0d) expected (0,1)", bus.row_cnt, bus.col_cnt);
    end
`ifdef LB_ERR_CHECK_EN
    n_checks++;
    if (line_err !== 1'b1) begin n_fail++; $display("FAIL sofmid_line_err: got %b expected 1", line_err); end
`endif
    for (int n = 1; n < W*H; n++) begin
      step(1, 0, pv(m_r, m_c, 8'h60));
      n_checks++;
      if (bus.win_valid !== exp_valid) begin
        n_fail++; $display("FAIL sofmid_valid n=%0d: got %b expected %b", n, bus.win_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (bus.win_out !== exp_win) begin n_fail++; $display("FAIL sofmid_win n=%0d: got %h expected %h", n, bus.win_out, exp_win); end
      end
      if (bus.win_valid === 1'b1 && first_n < 0) first_n = n;
    end
    n_checks++;
    if (first_n != 10) begin n_fail++; $display("FAIL sofmid_first: got %0d expected 10", first_n); end
`ifdef LB_ERR_CHECK_EN
    n_checks++;
    if (line_err !== 1'b1) begin n_fail++; $display("FAIL sofmid_sticky: got %b expected 1", line_err); end
    do_reset(1);
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", line_err); end
    for (int i = 0; i < W*H; i++) step(1, i == 0, pv(i / W, i % W, 0));
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL err_clean_frame: got %b expected 0", line_err); end
    step(1, 0, 24'h00);
    n_checks++;
    if (line_err !== 1'b1) begin n_fail++; $display("FAIL err_no_sof: got %b expected 1", line_err); end
`endif
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit s = (i == 0) || ($urandom_range(0, 60) == 0);
      step(v, s, DW'($urandom));
      n_checks++;
      if (bus.win_valid !== exp_valid) begin
        n_fail++; $display("FAIL rand_valid i=%0d: got %b expected %b", i, bus.win_valid, exp_valid);
      end
      if (exp_valid || (!v && m_have)) begin
        n_checks++;
        if (bus.win_out !== m_last) begin n_fail++; $display("FAIL rand_win i=%0d: got %h expected %h", i, bus.win_out, m_last); end
      end
      n_checks++;
      if (bus.col_cnt !== exp_col || bus.row_cnt !== exp_row) begin
        n_fail++; $display("FAIL rand_cnt i=%0d: got (%0d,%0d) expected (%0d,%0d)", i, bus.row_cnt, bus.col_cnt, exp_row, exp_col);
      end
    end
  endtask

  initial begin
    bus.pix_valid = 0;
    bus.sof       = 0;
    bus.pix_in    = '0;
    model_reset();
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_sof_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
